// File: rtl/reorder_buffer_mc.sv
// Multi-dispatch, multi-commit reorder buffer with CDB result capture and mispredict flush.
// Define ROB_PERF_CNT_EN to add saturating commit/flush/full-cycle performance counters.
module reorder_buffer_mc #(
    parameter int ENTRIES      = 16,
    parameter int ISSUE_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int CDB_LANES    = 4,
    parameter int WIDTH        = 32,
    parameter int TAG_W        = $clog2(ENTRIES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ISSUE_WIDTH-1:0]             disp_vld_i,
    output logic [ISSUE_WIDTH-1:0]             disp_rdy_o,
    input  logic [ISSUE_WIDTH-1:0][4:0]        disp_dest_i,
    input  logic [ISSUE_WIDTH-1:0][WIDTH-1:0]  disp_pc_i,
    input  logic [ISSUE_WIDTH-1:0]             disp_br_i,
    input  logic [ISSUE_WIDTH-1:0]             disp_pred_i,
    output logic [ISSUE_WIDTH-1:0][TAG_W-1:0]  disp_tag_o,
    input  logic [CDB_LANES-1:0]               cdb_vld_i,
    input  logic [CDB_LANES-1:0][TAG_W-1:0]    cdb_tag_i,
    input  logic [CDB_LANES-1:0][WIDTH-1:0]    cdb_data_i,
    input  logic [CDB_LANES-1:0]               cdb_taken_i,
    output logic [COMMIT_WIDTH-1:0]            commit_o,
    output logic [COMMIT_WIDTH-1:0][4:0]       commit_dest_o,
    output logic [COMMIT_WIDTH-1:0][WIDTH-1:0] commit_val_o,
    output logic [COMMIT_WIDTH-1:0][TAG_W-1:0] commit_tag_o,
    output logic                               flush_o,
    output logic [WIDTH-1:0]                   redirect_pc_o,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]                        perf_commits_o,
    output logic [31:0]                        perf_flushes_o,
    output logic [31:0]                        perf_full_cycles_o,
`endif
    output logic [TAG_W:0]                     count_o
);

    logic [ENTRIES-1:0]     r_valid;
    logic [ENTRIES-1:0]     r_done;
    logic [ENTRIES-1:0]     r_br;
    logic [ENTRIES-1:0]     r_pred;
    logic [ENTRIES-1:0]     r_taken;
    logic [4:0]             r_dest [ENTRIES];
    logic [WIDTH-1:0]       r_pc   [ENTRIES];
    logic [WIDTH-1:0]       r_data [ENTRIES];
    logic [TAG_W:0]         r_head;
    logic [TAG_W:0]         r_tail;
    logic [TAG_W:0]         r_count;

    logic [TAG_W:0]         w_free;
    logic [TAG_W:0]         w_nacc;
    logic [TAG_W:0]         w_nret;
    logic [ISSUE_WIDTH-1:0] w_acc;
    logic                   w_chain;
    logic                   w_stop;
    logic [TAG_W-1:0]       w_idx;

    assign count_o = r_count;

    // Dispatch handshake: readiness from registered occupancy only, acceptance contiguous from lane 0.
    always_comb begin
        disp_rdy_o = '0;
        disp_tag_o = '0;
        w_acc      = '0;
        w_nacc     = '0;
        w_chain    = 1'b1;
        w_free     = (TAG_W+1)'(ENTRIES) - r_count;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            disp_rdy_o[i] = rst_n && (w_free > (TAG_W+1)'(i));
            disp_tag_o[i] = rst_n ? (r_tail[TAG_W-1:0] + TAG_W'(i)) : '0;
            if (w_chain && disp_vld_i[i] && disp_rdy_o[i]) begin
                w_acc[i] = 1'b1;
                w_nacc   = w_nacc + (TAG_W+1)'(1);
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    // In-order retirement from head; a branch ends the commit group and may raise a flush.
    always_comb begin
        commit_o      = '0;
        commit_dest_o = '0;
        commit_val_o  = '0;
        commit_tag_o  = '0;
        flush_o       = 1'b0;
        redirect_pc_o = '0;
        w_nret        = '0;
        w_stop        = 1'b0;
        w_idx         = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_idx = r_head[TAG_W-1:0] + TAG_W'(k);
            if (!w_stop && r_valid[w_idx] && r_done[w_idx]) begin
                commit_o[k]     = 1'b1;
                commit_tag_o[k] = w_idx;
                w_nret          = w_nret + (TAG_W+1)'(1);
                if (r_br[w_idx]) begin
                    w_stop = 1'b1;
                    if (r_taken[w_idx] != r_pred[w_idx]) begin
                        flush_o       = 1'b1;
                        redirect_pc_o = r_taken[w_idx] ? r_data[w_idx] : (r_pc[w_idx] + WIDTH'(4));
                    end else begin
                        redirect_pc_o = '0;
                    end
                end else begin
                    commit_dest_o[k] = r_dest[w_idx];
                    commit_val_o[k]  = r_data[w_idx];
                end
            end else begin
                w_stop = 1'b1;
            end
        end
    end

    // Entry state: flush wipes the buffer; otherwise retire, allocate, then capture CDB results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
            r_br    <= '0;
            r_pred  <= '0;
            r_taken <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_dest[e] <= '0;
                r_pc[e]   <= '0;
                r_data[e] <= '0;
            end
        end else if (flush_o) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_o[k]) begin
                    r_valid[commit_tag_o[k]] <= 1'b0;
                    r_done[commit_tag_o[k]]  <= 1'b0;
                end
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (w_acc[i]) begin
                    r_valid[disp_tag_o[i]] <= 1'b1;
                    r_done[disp_tag_o[i]]  <= 1'b0;
                    r_br[disp_tag_o[i]]    <= disp_br_i[i];
                    r_pred[disp_tag_o[i]]  <= disp_pred_i[i];
                    r_dest[disp_tag_o[i]]  <= disp_dest_i[i];
                    r_pc[disp_tag_o[i]]    <= disp_pc_i[i];
                end
            end
            // Descending lane order so the lowest-indexed lane wins a duplicate tag.
            for (int l = CDB_LANES - 1; l >= 0; l--) begin
                if (cdb_vld_i[l] && r_valid[cdb_tag_i[l]] && !r_done[cdb_tag_i[l]]) begin
                    r_done[cdb_tag_i[l]]  <= 1'b1;
                    r_data[cdb_tag_i[l]]  <= cdb_data_i[l];
                    r_taken[cdb_tag_i[l]] <= cdb_taken_i[l];
                end
            end
            r_head  <= r_head + w_nret;
            r_tail  <= r_tail + w_nacc;
            r_count <= r_count + w_nacc - w_nret;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_flushes;
    logic [31:0] r_perf_full;
    logic [32:0] w_perf_sum;

    assign w_perf_sum         = {1'b0, r_perf_commits} + 33'(w_nret);
    assign perf_commits_o     = r_perf_commits;
    assign perf_flushes_o     = r_perf_flushes;
    assign perf_full_cycles_o = r_perf_full;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_commits <= '0;
            r_perf_flushes <= '0;
            r_perf_full    <= '0;
        end else begin
            r_perf_commits <= w_perf_sum[32] ? 32'hFFFF_FFFF : w_perf_sum[31:0];
            if (flush_o && (r_perf_flushes != 32'hFFFF_FFFF)) begin
                r_perf_flushes <= r_perf_flushes + 32'd1;
            end
            if ((r_count == (TAG_W+1)'(ENTRIES)) && (r_perf_full != 32'hFFFF_FFFF)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Self-checking bench for reorder_buffer_mc: directed scenarios plus randomized traffic
// checked against a queue-based program-order model.
module tb_reorder_buffer_mc;
    localparam int N  = 16;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int CL = 4;
    localparam int W  = 32;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [IW-1:0]         disp_vld_i, disp_rdy_o, disp_br_i, disp_pred_i;
    logic [IW-1:0][4:0]    disp_dest_i;
    logic [IW-1:0][W-1:0]  disp_pc_i;
    logic [IW-1:0][TW-1:0] disp_tag_o;
    logic [CL-1:0]         cdb_vld_i, cdb_taken_i;
    logic [CL-1:0][TW-1:0] cdb_tag_i;
    logic [CL-1:0][W-1:0]  cdb_data_i;
    logic [CW-1:0]         commit_o;
    logic [CW-1:0][4:0]    commit_dest_o;
    logic [CW-1:0][W-1:0]  commit_val_o;
    logic [CW-1:0][TW-1:0] commit_tag_o;
    logic                  flush_o;
    logic [W-1:0]          redirect_pc_o;
    logic [TW:0]           count_o;

    int checks = 0;
    int failures = 0;

    reorder_buffer_mc dut (
        .clk(clk), .rst_n(rst_n),
        .disp_vld_i(disp_vld_i), .disp_rdy_o(disp_rdy_o), .disp_dest_i(disp_dest_i),
        .disp_pc_i(disp_pc_i), .disp_br_i(disp_br_i), .disp_pred_i(disp_pred_i),
        .disp_tag_o(disp_tag_o),
        .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .cdb_taken_i(cdb_taken_i),
        .commit_o(commit_o), .commit_dest_o(commit_dest_o), .commit_val_o(commit_val_o),
        .commit_tag_o(commit_tag_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Program-order model: the queue holds the live instructions, oldest first.
    typedef struct {
        int          tag;
        logic [4:0]  dest;
        logic [31:0] pc;
        bit          br;
        bit          pred;
        bit          taken;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          mtail;
    logic [IW-1:0] exp_rdy;
    int          exp_nacc;
    logic [CW-1:0] exp_commit;
    logic [4:0]  exp_cdest [CW];
    logic [31:0] exp_cval  [CW];
    int          exp_ctag  [CW];
    bit          exp_cbr   [CW];
    logic        exp_flush;
    logic [31:0] exp_redir;
    int          exp_nret;

    task automatic idle_inputs();
        disp_vld_i = '0; disp_dest_i = '0; disp_pc_i = '0; disp_br_i = '0; disp_pred_i = '0;
        cdb_vld_i = '0; cdb_tag_i = '0; cdb_data_i = '0; cdb_taken_i = '0;
    endtask

    task automatic compute_expected();
        bit stop;
        stop = 0;
        exp_rdy = '0; exp_nacc = 0; exp_commit = '0; exp_flush = 1'b0; exp_redir = '0; exp_nret = 0;
        for (int i = 0; i < IW; i++) exp_rdy[i] = ((N - q.size()) > i);
        for (int i = 0; i < IW; i++)
            if (exp_nacc == i && disp_vld_i[i] && exp_rdy[i]) exp_nacc++;
        for (int k = 0; k < CW; k++) begin
            exp_cdest[k] = '0; exp_cval[k] = '0; exp_ctag[k] = 0; exp_cbr[k] = 0;
            if (!stop && k < q.size() && q[k].done) begin
                exp_commit[k] = 1'b1;
                exp_ctag[k] = q[k].tag;
                exp_cbr[k] = q[k].br;
                exp_nret++;
                if (q[k].br) begin
                    stop = 1;
                    if (q[k].taken != q[k].pred) begin
                        exp_flush = 1'b1;
                        exp_redir = q[k].taken ? q[k].data : q[k].pc + 32'd4;
                    end
                end else begin
                    exp_cdest[k] = q[k].dest;
                    exp_cval[k] = q[k].data;
                end
            end else begin
                stop = 1;
            end
        end
    endtask

    task automatic model_update();
        ent_t e;
        if (exp_flush) begin
            q.delete();
            mtail = 0;
            return;
        end
        for (int l = 0; l < CL; l++)
            if (cdb_vld_i[l])
                foreach (q[j])
                    if (q[j].tag == int'(cdb_tag_i[l]) && !q[j].done) begin
                        q[j].done = 1; q[j].data = cdb_data_i[l]; q[j].taken = cdb_taken_i[l];
                    end
        for (int k = 0; k < exp_nret; k++) void'(q.pop_front());
        for (int i = 0; i < exp_nacc; i++) begin
            e.tag = (mtail + i) % N; e.dest = disp_dest_i[i]; e.pc = disp_pc_i[i];
            e.br = disp_br_i[i]; e.pred = disp_pred_i[i]; e.taken = 0; e.done = 0; e.data = '0;
            q.push_back(e);
        end
        mtail = (mtail + exp_nacc) % N;
    endtask

    task automatic eval();
        #1;
        compute_expected();
    endtask

    task automatic tick();
        compute_expected();
        model_update();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        q.delete();
        mtail = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (disp_rdy_o !== 2'b00) begin failures++; $display("FAIL rst_rdy_low got=%b exp=00", disp_rdy_o); end
        checks++; if (count_o !== 5'd0) begin failures++; $display("FAIL rst_count_low got=%0d exp=0", count_o); end
        checks++; if (commit_o !== 2'b00 || flush_o !== 1'b0) begin failures++; $display("FAIL rst_commit_low got=%b/%b exp=00/0", commit_o, flush_o); end
        @(negedge clk);
        rst_n = 1'b1; q.delete(); mtail = 0;
        eval();
        checks++; if (disp_rdy_o !== 2'b11) begin failures++; $display("FAIL rst_rdy got=%b exp=11", disp_rdy_o); end
        checks++; if (disp_tag_o[0] !== 4'd0 || disp_tag_o[1] !== 4'd1) begin failures++; $display("FAIL rst_tags got=%0d,%0d exp=0,1", disp_tag_o[0], disp_tag_o[1]); end
        tick();
    endtask

    task automatic test_alu_pair();
        do_reset();
        disp_vld_i = 2'b11; disp_dest_i[0] = 5'd5; disp_dest_i[1] = 5'd6;
        eval();
        checks++; if (disp_tag_o[0] !== 4'd0 || disp_tag_o[1] !== 4'd1) begin failures++; $display("FAIL pair_tags got=%0d,%0d exp=0,1", disp_tag_o[0], disp_tag_o[1]); end
        tick();
        cdb_vld_i = 4'b0011; cdb_tag_i[0] = 4'd0; cdb_tag_i[1] = 4'd1; cdb_data_i[0] = 32'hA; cdb_data_i[1] = 32'hB;
        eval();
        checks++; if (commit_o !== 2'b00 || count_o !== 5'd2) begin failures++; $display("FAIL pair_pending got=%b/%0d exp=00/2", commit_o, count_o); end
        tick();
        eval();
        checks++; if (commit_o !== 2'b11) begin failures++; $display("FAIL pair_commit got=%b exp=11", commit_o); end
        checks++; if (commit_dest_o[0] !== 5'd5 || commit_dest_o[1] !== 5'd6) begin failures++; $display("FAIL pair_dest got=%0d,%0d exp=5,6", commit_dest_o[0], commit_dest_o[1]); end
        checks++; if (commit_val_o[0] !== 32'hA || commit_val_o[1] !== 32'hB) begin failures++; $display("FAIL pair_val got=%h,%h exp=a,b", commit_val_o[0], commit_val_o[1]); end
        checks++; if (commit_tag_o[0] !== 4'd0 || commit_tag_o[1] !== 4'd1 || flush_o !== 1'b0) begin failures++; $display("FAIL pair_tag got=%0d,%0d fl=%b exp=0,1,0", commit_tag_o[0], commit_tag_o[1], flush_o); end
        tick();
        eval();
        checks++; if (count_o !== 5'd0) begin failures++; $display("FAIL pair_count got=%0d exp=0", count_o); end
        tick();
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            disp_vld_i = 2'b11; disp_dest_i[0] = 5'(2 * c + 1); disp_dest_i[1] = 5'(2 * c + 2);
            eval();
            tick();
        end
        disp_vld_i = 2'b11;
        eval();
        checks++; if (count_o !== 5'd16 || disp_rdy_o !== 2'b00) begin failures++; $display("FAIL full_state got=%0d/%b exp=16/00", count_o, disp_rdy_o); end
        tick();
        cdb_vld_i = 4'b0001; cdb_tag_i[0] = 4'd0; cdb_data_i[0] = 32'h123;
        eval();
        tick();
        disp_vld_i = 2'b11;
        eval();
        checks++; if (commit_o !== 2'b01 || commit_tag_o[0] !== 4'd0 || disp_rdy_o !== 2'b00) begin failures++; $display("FAIL full_commit got=%b/%0d/%b exp=01/0/00", commit_o, commit_tag_o[0], disp_rdy_o); end
        tick();
        disp_vld_i = 2'b11;
        eval();
        checks++; if (count_o !== 5'd15 || disp_rdy_o !== 2'b01 || disp_tag_o[0] !== 4'd0) begin failures++; $display("FAIL full_free1 got=%0d/%b/%0d exp=15/01/0", count_o, disp_rdy_o, disp_tag_o[0]); end
        tick();
        eval();
        checks++; if (count_o !== 5'd16 || disp_rdy_o !== 2'b00) begin failures++; $display("FAIL full_refill got=%0d/%b exp=16/00", count_o, disp_rdy_o); end
        tick();
    endtask

    task automatic test_mispredict();
        do_reset();
        disp_vld_i = 2'b11; disp_dest_i[0] = 5'd1; disp_dest_i[1] = 5'd2;
        eval(); tick();
        disp_vld_i = 2'b01; disp_br_i = 2'b01; disp_pred_i = 2'b00; disp_pc_i[0] = 32'h1000;
        eval(); tick();
        cdb_vld_i = 4'b0111; cdb_tag_i[0] = 4'd0; cdb_tag_i[1] = 4'd1; cdb_tag_i[2] = 4'd2;
        cdb_data_i[0] = 32'h11; cdb_data_i[1] = 32'h22; cdb_data_i[2] = 32'h8000_0100; cdb_taken_i = 4'b0100;
        eval(); tick();
        eval();
        checks++; if (commit_o !== 2'b11 || flush_o !== 1'b0) begin failures++; $display("FAIL mp_first got=%b/%b exp=11/0", commit_o, flush_o); end
        tick();
        disp_vld_i = 2'b11; cdb_vld_i = 4'b0001; cdb_tag_i[0] = 4'd3;
        eval();
        checks++; if (commit_o !== 2'b01 || commit_tag_o[0] !== 4'd2 || commit_dest_o[0] !== 5'd0) begin failures++; $display("FAIL mp_branch got=%b/%0d/%0d exp=01/2/0", commit_o, commit_tag_o[0], commit_dest_o[0]); end
        checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h8000_0100) begin failures++; $display("FAIL mp_redirect got=%b/%h exp=1/80000100", flush_o, redirect_pc_o); end
        tick();
        eval();
        checks++; if (count_o !== 5'd0 || commit_o !== 2'b00 || disp_tag_o[0] !== 4'd0) begin failures++; $display("FAIL mp_after got=%0d/%b/%0d exp=0/00/0", count_o, commit_o, disp_tag_o[0]); end
        tick();
    endtask

    task automatic test_correct_branch();
        do_reset();
        disp_vld_i = 2'b11; disp_br_i = 2'b01; disp_pred_i = 2'b01; disp_pc_i[0] = 32'h2000; disp_dest_i[1] = 5'd7;
        eval(); tick();
        cdb_vld_i = 4'b0011; cdb_tag_i[0] = 4'd0; cdb_tag_i[1] = 4'd1; cdb_taken_i = 4'b0001;
        cdb_data_i[0] = 32'h2040; cdb_data_i[1] = 32'h55;
        eval(); tick();
        eval();
        checks++; if (commit_o !== 2'b01 || commit_dest_o[0] !== 5'd0 || flush_o !== 1'b0 || redirect_pc_o !== 32'd0) begin failures++; $display("FAIL cb_branch got=%b/%0d/%b/%h exp=01/0/0/0", commit_o, commit_dest_o[0], flush_o, redirect_pc_o); end
        tick();
        eval();
        checks++; if (commit_o !== 2'b01 || commit_tag_o[0] !== 4'd1 || commit_dest_o[0] !== 5'd7 || commit_val_o[0] !== 32'h55) begin failures++; $display("FAIL cb_alu got=%b/%0d/%0d/%h exp=01/1/7/55", commit_o, commit_tag_o[0], commit_dest_o[0], commit_val_o[0]); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 42; c++) begin
            if (c < 40) begin
                disp_vld_i = 2'b01; disp_dest_i[0] = 5'((c % 31) + 1); disp_pc_i[0] = 32'h100 + 32'(c * 4);
            end
            if (c >= 1 && c <= 40) begin
                cdb_vld_i = 4'b0001; cdb_tag_i[0] = 4'((c - 1) % N); cdb_data_i[0] = 32'h1000 + 32'(c - 1);
            end
            eval();
            if (c < 40) begin
                checks++; if (disp_tag_o[0] !== 4'(c % N)) begin failures++; $display("FAIL wrap_tag c=%0d got=%0d exp=%0d", c, disp_tag_o[0], c % N); end
            end
            if (c >= 2) begin
                checks++; if (commit_o !== 2'b01 || commit_tag_o[0] !== 4'((c - 2) % N) || commit_val_o[0] !== 32'h1000 + 32'(c - 2)) begin failures++; $display("FAIL wrap_commit c=%0d got=%b/%0d/%h exp=01/%0d/%h", c, commit_o, commit_tag_o[0], commit_val_o[0], (c - 2) % N, 32'h1000 + 32'(c - 2)); end
            end else begin
                checks++; if (commit_o !== 2'b00) begin failures++; $display("FAIL wrap_idle c=%0d got=%b exp=00", c, commit_o); end
            end
            checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL wrap_flush c=%0d got=%b exp=0", c, flush_o); end
            tick();
        end
        eval();
        checks++; if (count_o !== 5'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        disp_vld_i = 2'b11; disp_dest_i[0] = 5'd3; disp_dest_i[1] = 5'd4;
        eval(); tick();
        disp_vld_i = 2'b11; disp_dest_i[0] = 5'd5; disp_dest_i[1] = 5'd6;
        cdb_vld_i = 4'b0011; cdb_tag_i[0] = 4'd0; cdb_tag_i[1] = 4'd1;
        eval(); tick();
        disp_vld_i = 2'b11; cdb_vld_i = 4'b0001; cdb_tag_i[0] = 4'd2;
        eval();
        checks++; if (commit_o !== 2'b11 || count_o !== 5'd4) begin failures++; $display("FAIL ar_before got=%b/%0d exp=11/4", commit_o, count_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (commit_o !== 2'b00 || count_o !== 5'd0 || disp_rdy_o !== 2'b00 || flush_o !== 1'b0) begin failures++; $display("FAIL ar_clear got=%b/%0d/%b/%b exp=00/0/00/0", commit_o, count_o, disp_rdy_o, flush_o); end
        q.delete(); mtail = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        eval();
        checks++; if (count_o !== 5'd0 || disp_rdy_o !== 2'b11) begin failures++; $display("FAIL ar_release got=%0d/%b exp=0/11", count_o, disp_rdy_o); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            disp_vld_i = 2'($urandom_range(0, 3));
            for (int i = 0; i < IW; i++) begin
                disp_dest_i[i] = 5'($urandom_range(0, 31));
                disp_pc_i[i]   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                disp_br_i[i]   = ($urandom_range(0, 7) == 0);
                disp_pred_i[i] = 1'($urandom_range(0, 1));
            end
            for (int l = 0; l < CL; l++) begin
                cdb_vld_i[l]   = 1'($urandom_range(0, 1));
                cdb_tag_i[l]   = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                                 4'(q[$urandom_range(0, q.size() - 1)].tag) : 4'($urandom_range(0, N - 1));
                cdb_data_i[l]  = $urandom;
                cdb_taken_i[l] = 1'($urandom_range(0, 1));
            end
            eval();
            checks++; if (disp_rdy_o !== exp_rdy) begin failures++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, disp_rdy_o, exp_rdy); end
            checks++; if (count_o !== 5'(q.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count_o, q.size()); end
            checks++; if (disp_tag_o[0] !== 4'(mtail) || disp_tag_o[1] !== 4'((mtail + 1) % N)) begin failures++; $display("FAIL rnd_tag c=%0d got=%0d,%0d exp=%0d", c, disp_tag_o[0], disp_tag_o[1], mtail); end
            checks++; if (commit_o !== exp_commit) begin failures++; $display("FAIL rnd_commit c=%0d got=%b exp=%b", c, commit_o, exp_commit); end
            checks++; if (flush_o !== exp_flush || redirect_pc_o !== exp_redir) begin failures++; $display("FAIL rnd_flush c=%0d got=%b/%h exp=%b/%h", c, flush_o, redirect_pc_o, exp_flush, exp_redir); end
            for (int k = 0; k < CW; k++) begin
                if (exp_commit[k]) begin
                    checks++; if (commit_tag_o[k] !== 4'(exp_ctag[k]) || commit_dest_o[k] !== exp_cdest[k]) begin failures++; $display("FAIL rnd_lane%0d c=%0d got=%0d/%0d exp=%0d/%0d", k, c, commit_tag_o[k], commit_dest_o[k], exp_ctag[k], exp_cdest[k]); end
                    if (!exp_cbr[k]) begin
                        checks++; if (commit_val_o[k] !== exp_cval[k]) begin failures++; $display("FAIL rnd_val%0d c=%0d got=%h exp=%h", k, c, commit_val_o[k], exp_cval[k]); end
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_pair();
        test_fill_full();
        test_mispredict();
        test_correct_branch();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
